// File: rtl/pc_pkg.sv
// Shared types and constants for the SAP-2 program counter with return stack.
package pc_pkg;

  // One PC operation is selected per cycle by the priority encoder.
  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_BRANCH,
    PC_LOAD,
    PC_CALL,
    PC_RET
  } pc_op_t;

  localparam int unsigned PC_RESET_VECTOR = 0;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses. Push is ignored when full and pop when empty;
// top_data is read from registered state at entry count-1.
module return_stack #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [ADDR_WIDTH-1:0]         push_data,
  output logic [ADDR_WIDTH-1:0]         top_data,
  output logic [$clog2(STACK_DEPTH):0]  count,
  output logic                          full,
  output logic                          empty
);

  localparam int unsigned PtrW = $clog2(STACK_DEPTH);

  logic [PtrW:0]           count_q, count_d;
  logic [ADDR_WIDTH-1:0]   mem_q [STACK_DEPTH];
  logic [PtrW-1:0]         top_idx;
  logic                    do_push, do_pop;

  assign full    = (count_q == (PtrW+1)'(STACK_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !do_push;
  // Wraps to the last slot when empty; top_data is then a don't-care.
  assign top_idx  = count_q[PtrW-1:0] - PtrW'(1);
  assign top_data = mem_q[top_idx];
  assign count    = count_q;

  // Next occupancy.
  always_comb begin
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + (PtrW+1)'(1);
    end else if (do_pop) begin
      count_d = count_q - (PtrW+1)'(1);
    end
  end

  // Occupancy register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is not cleared on reset; only the occupancy matters.
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem_q[count_q[PtrW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/program_counter_stack.sv
// SAP-2 program counter: increment, absolute load, signed relative branch,
// and call/return through a hardware return stack with sticky error flags.
module program_counter_stack
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned OFFSET_WIDTH = 8,
  parameter int unsigned STACK_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          load,
  input  logic [ADDR_WIDTH-1:0]         load_addr,
  input  logic                          branch,
  input  logic [OFFSET_WIDTH-1:0]       branch_offset,
  input  logic                          call,
  input  logic                          ret,
  output logic [ADDR_WIDTH-1:0]         counter_out,
  output logic [$clog2(STACK_DEPTH):0]  stack_count,
  output logic                          stack_full,
  output logic                          stack_empty,
  output logic                          stack_overflow,
  output logic                          stack_underflow
);

  pc_op_t                 op;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  branch_ext;
  logic [ADDR_WIDTH-1:0]  top_data;
  logic                   ovf_q, ovf_d;
  logic                   udf_q, udf_d;
  logic                   push, pop;
  logic                   full, empty;

  // Sizing cast of a signed value sign-extends the offset to address width.
  assign branch_ext = ADDR_WIDTH'($signed(branch_offset));

  // Reduce the request lines to one operation, ret highest.
  always_comb begin
    op = PC_HOLD;
    if (ret) begin
      op = PC_RET;
    end else if (call) begin
      op = PC_CALL;
    end else if (load) begin
      op = PC_LOAD;
    end else if (branch) begin
      op = PC_BRANCH;
    end else if (enable) begin
      op = PC_INC;
    end
  end

  // Next PC, stack control and sticky flag updates for the selected op.
  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    push  = 1'b0;
    pop   = 1'b0;
    unique case (op)
      PC_INC:    pc_d = pc_q + ADDR_WIDTH'(1);
      PC_BRANCH: pc_d = pc_q + branch_ext;
      PC_LOAD:   pc_d = load_addr;
      PC_CALL: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          push = 1'b1;
          pc_d = load_addr;
        end
      end
      PC_RET: begin
        if (empty) begin
          udf_d = 1'b1;
        end else begin
          pop  = 1'b1;
          pc_d = top_data;
        end
      end
      default: ;
    endcase
  end

  // PC and sticky flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= ADDR_WIDTH'(PC_RESET_VECTOR);
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  return_stack #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_q),
    .top_data  (top_data),
    .count     (stack_count),
    .full      (full),
    .empty     (empty)
  );

  assign counter_out     = pc_q;
  assign stack_full      = full;
  assign stack_empty     = empty;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = udf_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed test of program_counter_stack with default parameters.
module tb_program_counter_stack;

  logic        clk = 1'b0;
  logic        reset, enable, load, branch, call, ret;
  logic [15:0] load_addr;
  logic [7:0]  branch_offset;
  logic [15:0] counter_out;
  logic [3:0]  stack_count;
  logic        stack_full, stack_empty, stack_overflow, stack_underflow;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  program_counter_stack dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .load            (load),
    .load_addr       (load_addr),
    .branch          (branch),
    .branch_offset   (branch_offset),
    .call            (call),
    .ret             (ret),
    .counter_out     (counter_out),
    .stack_count     (stack_count),
    .stack_full      (stack_full),
    .stack_empty     (stack_empty),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  task automatic idle();
    reset = 0; enable = 0; load = 0; branch = 0; call = 0; ret = 0;
    load_addr = '0; branch_offset = '0;
  endtask

  // Apply the current inputs for one edge, sample 1 time unit later, then idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [15:0] pc, input logic [3:0] cnt,
                             input logic ovf, input logic udf);
    check({tag, ".pc"}, {16'h0, counter_out}, {16'h0, pc});
    check({tag, ".count"}, {28'h0, stack_count}, {28'h0, cnt});
    check({tag, ".full"}, {31'h0, stack_full}, {31'h0, cnt == 4'd8});
    check({tag, ".empty"}, {31'h0, stack_empty}, {31'h0, cnt == 4'd0});
    check({tag, ".ovf"}, {31'h0, stack_overflow}, {31'h0, ovf});
    check({tag, ".udf"}, {31'h0, stack_underflow}, {31'h0, udf});
  endtask

  initial begin
    idle();
    reset = 1; tick();
    check_state("reset", 16'h0000, 4'd0, 0, 0);

    // Increment and wrap.
    enable = 1; tick(); check_state("inc1", 16'h0001, 4'd0, 0, 0);
    enable = 1; tick(); check_state("inc2", 16'h0002, 4'd0, 0, 0);
    enable = 1; tick(); check_state("inc3", 16'h0003, 4'd0, 0, 0);
    load = 1; load_addr = 16'hFFFF; tick(); check_state("load_ffff", 16'hFFFF, 4'd0, 0, 0);
    enable = 1; tick(); check_state("inc_wrap", 16'h0000, 4'd0, 0, 0);

    // Relative branches.
    load = 1; load_addr = 16'h0010; tick();
    branch = 1; branch_offset = 8'hF0; tick(); check_state("br_m16", 16'h0000, 4'd0, 0, 0);
    load = 1; load_addr = 16'h0010; tick();
    branch = 1; branch_offset = 8'h7F; tick(); check_state("br_p127", 16'h008F, 4'd0, 0, 0);
    load = 1; load_addr = 16'h0005; tick();
    branch = 1; branch_offset = 8'hF0; tick(); check_state("br_wrap", 16'hFFF5, 4'd0, 0, 0);

    // Nested call/return.
    load = 1; load_addr = 16'h0020; tick();
    call = 1; load_addr = 16'h0100; tick(); check_state("call1", 16'h0100, 4'd1, 0, 0);
    call = 1; load_addr = 16'h0200; tick(); check_state("call2", 16'h0200, 4'd2, 0, 0);
    ret = 1; tick(); check_state("ret1", 16'h0100, 4'd1, 0, 0);
    ret = 1; tick(); check_state("ret2", 16'h0020, 4'd0, 0, 0);

    // Fill the stack, overflow, drain, underflow.
    load = 1; load_addr = 16'h0000; tick();
    for (int i = 0; i < 8; i++) begin
      call = 1; load_addr = 16'h1000 + 16'(i); tick();
      check_state($sformatf("fill%0d", i), 16'h1000 + 16'(i), 4'(i + 1), 0, 0);
    end
    call = 1; load_addr = 16'h2000; tick(); check_state("ovf_call", 16'h1007, 4'd8, 1, 0);
    for (int i = 7; i >= 0; i--) begin
      ret = 1; tick();
      check_state($sformatf("drain%0d", i), (i == 0) ? 16'h0000 : 16'h1000 + 16'(i - 1),
                  4'(i), 1, 0);
    end
    load = 1; load_addr = 16'h0042; tick();
    ret = 1; tick(); check_state("udf_ret", 16'h0042, 4'd0, 1, 1);

    // Priority: ret beats everything below it.
    reset = 1; tick(); check_state("reset2", 16'h0000, 4'd0, 0, 0);
    load = 1; load_addr = 16'h0030; tick();
    call = 1; load_addr = 16'h0040; tick(); check_state("prio_call", 16'h0040, 4'd1, 0, 0);
    ret = 1; call = 1; load = 1; load_addr = 16'h0050; branch = 1; branch_offset = 8'h10;
    enable = 1; tick(); check_state("prio_ret", 16'h0030, 4'd0, 0, 0);
    call = 1; load_addr = 16'h0040; tick();
    reset = 1; ret = 1; call = 1; load = 1; load_addr = 16'h0050; branch = 1;
    branch_offset = 8'h10; enable = 1; tick(); check_state("prio_reset", 16'h0000, 4'd0, 0, 0);

    // Reset with a partly filled stack.
    call = 1; load_addr = 16'h0100; tick();
    call = 1; load_addr = 16'h0200; tick();
    call = 1; load_addr = 16'h0300; tick(); check_state("three_calls", 16'h0300, 4'd3, 0, 0);
    reset = 1; tick(); check_state("mid_reset", 16'h0000, 4'd0, 0, 0);
    ret = 1; tick(); check_state("post_reset_ret", 16'h0000, 4'd0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_counter_stack.md
# program_counter_stack

Parametrised program counter for the SAP-2 datapath with increment, absolute load, signed relative branch and a hardware call/return stack. Sits in the CPU core between the controller/sequencer (which issues one PC operation per cycle) and the memory address register (which consumes `counter_out`). It adds subroutine support and overflow/underflow detection, replacing the plain load/increment counter.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, width of program address; ≥ 4.
- `OFFSET_WIDTH`, 8, width of signed branch offset; ≤ `ADDR_WIDTH`.
- `STACK_DEPTH`, 8, return-stack entries; power of two, ≥ 2.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  increment PC by 1.
- `load`  in  1  absolute jump to `load_addr`.
- `load_addr`  in  ADDR_WIDTH  jump target.
- `branch`  in  1  relative jump by `branch_offset`.
- `branch_offset`  in  OFFSET_WIDTH  two's-complement offset.
- `call`  in  1  push return address, jump to `load_addr`.
- `ret`  in  1  pop return address into PC.
- `counter_out`  out  ADDR_WIDTH  current PC.
- `stack_count`  out  $clog2(STACK_DEPTH)+1  occupied entries.
- `stack_full`  out  1  `stack_count == STACK_DEPTH`.
- `stack_empty`  out  1  `stack_count == 0`.
- `stack_overflow`  out  1  sticky: call attempted while full.
- `stack_underflow`  out  1  sticky: ret attempted while empty.

## Operation
- Priority per cycle: `reset` > `ret` > `call` > `load` > `branch` > `enable` > hold. Only the highest asserted op takes effect; others ignored, no side effects.
- Reset: `counter_out`=0, `stack_count`=0, both sticky flags=0. Stack RAM contents not cleared (don't-care).
- Increment: `counter_out` ← `counter_out`+1, wraps at 2^ADDR_WIDTH−1 → 0.
- Load: `counter_out` ← `load_addr`.
- Branch: `counter_out` ← `counter_out` + sign_extend(`branch_offset`), modulo 2^ADDR_WIDTH (wraps both directions).
- Call, not full: push current `counter_out` (controller has already advanced past the CALL instruction and operand), `counter_out` ← `load_addr`, count+1.
- Call, full: no push, PC unchanged, `stack_overflow` ← 1.
- Ret, not empty: `counter_out` ← top entry, count−1.
- Ret, empty: PC unchanged, `stack_underflow` ← 1.
- Sticky flags clear only on reset.
- Internal priority encoder reduces inputs to one `pc_op_t` per cycle; update logic is a case on that op.

## Timing
- All outputs registered or decoded purely from registered state; no combinational path from any input to any output.
- Latency 1: op sampled on edge N, new `counter_out`/`stack_count`/flags visible after edge N.
- Back-to-back calls/rets every cycle supported; ret in cycle after call returns the just-pushed address.
- Sticky flag asserts in the cycle after the offending op.
- Reset asserted mid-sequence (any stack depth) returns all outputs to reset values after the next edge; ops in that cycle ignored.

## Structure
- Package `pc_pkg`: enum `pc_op_t` {PC_HOLD, PC_INC, PC_BRANCH, PC_LOAD, PC_CALL, PC_RET}; constant `PC_RESET_VECTOR` = 0.
- Sub-module `return_stack`: LIFO, `STACK_DEPTH`×`ADDR_WIDTH`, ports push/pop/push_data/top_data/count/full/empty; push ignored when full, pop ignored when empty; top_data = entry at count−1 (read from registered state).
- Top level holds the PC register, priority encoder, branch adder, sticky flags.

## Test plan
- Reset then `enable` for 3 cycles → `counter_out` 0,1,2,3; with ADDR_WIDTH=16 from 0xFFFF, `enable` → 0x0000.
- `counter_out`=0x0010, `branch`, offset 8'hF0 (−16) → 0x0000; offset 8'h7F → 0x008F; at 0x0005 offset −16 → 0xFFF5.
- `counter_out`=0x0020, `call` to 0x0100; then `call` to 0x0200; `ret` → 0x0100; `ret` → 0x0020; `stack_count` 1,2,1,0.
- STACK_DEPTH=8: 8 calls → `stack_full`=1; 9th call → PC and count unchanged, `stack_overflow`=1 and stays 1 through 8 rets; then `ret` on empty → `stack_underflow`=1, PC unchanged.
- All of `ret`,`call`,`load`,`branch`,`enable` asserted with stack depth 1 → only ret occurs; with `reset` also asserted → all outputs 0.
- Three calls then `reset` → `counter_out`=0, `stack_empty`=1, flags 0; subsequent `ret` → underflow flag set.
